// File: rtl/ring_sequence_checker_pkg.sv
// Shared types and helpers for the ring sequence checker.
// Holds the FSM state type, index width and rotate helpers.
package ring_pkg;

   localparam int MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   function automatic int idx_w(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

   // Only the low w bits of the result are meaningful.
   function automatic logic [MAX_W-1:0] rotl(
      input logic [MAX_W-1:0] v,
      input int               w
   );
      logic [MAX_W-1:0] m;
      m = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
      return ((v << 1) | (v >> (w - 1))) & m;
   endfunction

endpackage

// File: rtl/ring_sequence_checker_if.sv
// Sample-in / status-out bundle of the ring sequence checker.
// master drives samples, slave is the checker.
interface ring_sequence_checker_if #(
   parameter int WIDTH     = 4,
   parameter int ERR_CNT_W = 8
);
   import ring_pkg::*;

   localparam int IDX_W = idx_w(WIDTH);

   logic                 en;
   logic [WIDTH-1:0]     ring_in;
   logic [IDX_W-1:0]     idx;
   logic                 idx_valid;
   logic                 locked;
   logic                 onehot_err;
   logic                 step_err;
   logic                 wrap;
   logic [ERR_CNT_W-1:0] err_count;

   modport master (
      output en, ring_in,
      input  idx, idx_valid, locked,
      input  onehot_err, step_err, wrap,
      input  err_count
   );

   modport slave (
      input  en, ring_in,
      output idx, idx_valid, locked,
      output onehot_err, step_err, wrap,
      output err_count
   );
endinterface

// File: rtl/ring_sequence_checker_onehot_to_index.sv
// One-hot to binary encoder with legality flag.
// The index is only meaningful when o_onehot is set.
module onehot_to_index #(
   parameter int WIDTH = 4,
   parameter int IDX_W = 2
) (
   input  logic [WIDTH-1:0] i_vec,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_onehot
);

   int w_cnt;

   always_comb begin
      w_cnt = 0;
      o_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i_vec[i]) begin
            w_cnt = w_cnt + 1;
            o_idx = o_idx | IDX_W'(i);
         end
      end
      o_onehot = (w_cnt == 1);
   end

endmodule

// File: rtl/ring_sequence_checker.sv
// Checks a sampled ring code for one-hot legality and single-step rotation.
// Reports index, lock, error pulses, wrap pulse and a saturating error count.
module ring_sequence_checker
   import ring_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int LOCK_CNT  = 2,
   parameter int ERR_CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   ring_sequence_checker_if.slave  bus
);

   localparam int IDX_W = idx_w(WIDTH);
   localparam int GCW   = $clog2(LOCK_CNT + 1);

   state_t               r_state, w_state;
   logic [GCW-1:0]       r_good, w_good, w_good_inc;
   logic [WIDTH-1:0]     r_prev, w_prev, w_exp;
   logic [IDX_W-1:0]     r_idx, w_idx_n, w_idx;
   logic                 r_valid, w_valid;
   logic                 r_locked, w_locked;
   logic                 r_oh, w_oh;
   logic                 r_st, w_st;
   logic                 r_wrap, w_wrap;
   logic [ERR_CNT_W-1:0] r_err, w_err;
   logic                 w_onehot;

   onehot_to_index #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_enc (
      .i_vec    (bus.ring_in),
      .o_idx    (w_idx),
      .o_onehot (w_onehot)
   );

   assign w_exp = WIDTH'(rotl(MAX_W'(r_prev), WIDTH));

   assign w_good_inc = (r_good == GCW'(LOCK_CNT)) ?
                       r_good : r_good + 1'b1;

   always_comb begin
      w_state  = r_state;
      w_good   = r_good;
      w_prev   = r_prev;
      w_idx_n  = r_idx;
      w_valid  = r_valid;
      w_locked = r_locked;
      w_oh     = 1'b0;
      w_st     = 1'b0;
      w_wrap   = 1'b0;
      if (bus.en) begin
         if (!w_onehot) begin
            // prev is kept; IDLE ignores it until a legal sample arrives
            w_oh     = 1'b1;
            w_valid  = 1'b0;
            w_locked = 1'b0;
            w_good   = '0;
            w_state  = IDLE;
         end else begin
            w_prev  = bus.ring_in;
            w_idx_n = w_idx;
            w_valid = 1'b1;
            unique case (r_state)
               IDLE: begin
                  w_good   = '0;
                  w_locked = 1'b0;
                  w_state  = TRACK;
               end
               TRACK, LOCKED: begin
                  if (bus.ring_in == w_exp) begin
                     w_good = w_good_inc;
                     w_wrap = (r_idx == IDX_W'(WIDTH - 1));
                     if (w_good_inc == GCW'(LOCK_CNT)) begin
                        w_state  = LOCKED;
                        w_locked = 1'b1;
                     end else begin
                        w_state  = TRACK;
                     end
                  end else begin
                     w_st     = 1'b1;
                     w_locked = 1'b0;
                     w_good   = '0;
                     w_state  = TRACK;
                  end
               end
               default: begin
                  w_state  = IDLE;
                  w_locked = 1'b0;
               end
            endcase
         end
      end
   end

   always_comb begin
      w_err = r_err;
      if ((w_oh || w_st) && (r_err != '1)) begin
         w_err = r_err + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_good   <= '0;
         r_prev   <= '0;
         r_idx    <= '0;
         r_valid  <= 1'b0;
         r_locked <= 1'b0;
         r_oh     <= 1'b0;
         r_st     <= 1'b0;
         r_wrap   <= 1'b0;
         r_err    <= '0;
      end else begin
         r_state  <= w_state;
         r_good   <= w_good;
         r_prev   <= w_prev;
         r_idx    <= w_idx_n;
         r_valid  <= w_valid;
         r_locked <= w_locked;
         r_oh     <= w_oh;
         r_st     <= w_st;
         r_wrap   <= w_wrap;
         r_err    <= w_err;
      end
   end

   assign bus.idx        = r_idx;
   assign bus.idx_valid  = r_valid;
   assign bus.locked     = r_locked;
   assign bus.onehot_err = r_oh;
   assign bus.step_err   = r_st;
   assign bus.wrap       = r_wrap;
   assign bus.err_count  = r_err;

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Bench for ring_sequence_checker: index/step model plus directed vectors.
// Two instances: default parameters and a 2-bit error counter.
module tb_ring_sequence_checker;

   localparam int W  = 4;
   localparam int LC = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ring_sequence_checker_if #(.WIDTH(W), .ERR_CNT_W(8)) b0 ();
   ring_sequence_checker_if #(.WIDTH(W), .ERR_CNT_W(2)) b1 ();

   ring_sequence_checker #(
      .WIDTH (W), .LOCK_CNT (LC), .ERR_CNT_W (8)
   ) dut0 (
      .clk (clk), .reset (reset), .bus (b0.slave)
   );

   ring_sequence_checker #(
      .WIDTH (W), .LOCK_CNT (LC), .ERR_CNT_W (2)
   ) dut1 (
      .clk (clk), .reset (reset), .bus (b1.slave)
   );

   // model state, per instance: sequence is tracked by integer index
   bit m_have[2];
   int m_pidx[2];
   int m_streak[2];
   int m_idx[2];
   bit m_valid[2];
   bit m_locked[2];
   bit m_oh[2];
   bit m_st[2];
   bit m_wrap[2];
   int m_err[2];
   int m_emax[2];

   initial begin
      m_emax[0] = 255;
      m_emax[1] = 3;
   end

   task automatic model_clear(input int d);
      m_have[d] = 0; m_pidx[d] = 0; m_streak[d] = 0;
      m_idx[d] = 0; m_valid[d] = 0; m_locked[d] = 0;
      m_oh[d] = 0; m_st[d] = 0; m_wrap[d] = 0; m_err[d] = 0;
   endtask

   task automatic model_step(input int d, input logic e,
                             input logic [W-1:0] r);
      int n;
      m_oh[d] = 0; m_st[d] = 0; m_wrap[d] = 0;
      if (!e) return;
      if ($countones(r) != 1) begin
         m_oh[d] = 1; m_valid[d] = 0; m_locked[d] = 0;
         m_streak[d] = 0; m_have[d] = 0;
         if (m_err[d] < m_emax[d]) m_err[d]++;
         return;
      end
      n = 0;
      for (int i = 0; i < W; i++) if (r[i]) n = i;
      if (m_have[d] && n == (m_pidx[d] + 1) % W) begin
         if (m_streak[d] < LC) m_streak[d]++;
         m_locked[d] = (m_streak[d] == LC);
         m_wrap[d] = (m_pidx[d] == W - 1);
      end else if (m_have[d]) begin
         m_st[d] = 1; m_locked[d] = 0; m_streak[d] = 0;
         if (m_err[d] < m_emax[d]) m_err[d]++;
      end else begin
         m_streak[d] = 0; m_locked[d] = 0;
      end
      m_have[d] = 1; m_pidx[d] = n;
      m_idx[d] = n; m_valid[d] = 1;
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         model_clear(0);
         model_clear(1);
      end else begin
         model_step(0, b0.en, b0.ring_in);
         model_step(1, b1.en, b1.ring_in);
      end
   end

   task automatic cmp(input int d, input int idx, input bit v,
                      input bit lk, input bit oh, input bit st,
                      input bit wr, input int ec);
      n_checks++;
      if (idx != m_idx[d] || v != m_valid[d] || lk != m_locked[d] ||
          oh != m_oh[d] || st != m_st[d] || wr != m_wrap[d] ||
          ec != m_err[d]) begin
         n_fail++;
         $display("FAIL model dut%0d t=%0t got idx=%0d v=%0b lk=%0b oh=%0b st=%0b wr=%0b ec=%0d exp idx=%0d v=%0b lk=%0b oh=%0b st=%0b wr=%0b ec=%0d",
                  d, $time, idx, v, lk, oh, st, wr, ec,
                  m_idx[d], m_valid[d], m_locked[d], m_oh[d],
                  m_st[d], m_wrap[d], m_err[d]);
      end
   endtask

   always @(posedge clk) begin
      #1;
      cmp(0, int'(b0.idx), b0.idx_valid, b0.locked, b0.onehot_err,
          b0.step_err, b0.wrap, int'(b0.err_count));
      cmp(1, int'(b1.idx), b1.idx_valid, b1.locked, b1.onehot_err,
          b1.step_err, b1.wrap, int'(b1.err_count));
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input int d, input logic e,
                       input logic [W-1:0] r);
      @(negedge clk);
      if (d == 0) begin
         b0.en = e; b0.ring_in = r;
      end else begin
         b1.en = e; b1.ring_in = r;
      end
      @(posedge clk);
      #2;
   endtask

   task automatic chk_zero0(input string nm);
      chk({nm, "_idx"}, int'(b0.idx), 0);
      chk({nm, "_v"}, int'(b0.idx_valid), 0);
      chk({nm, "_lk"}, int'(b0.locked), 0);
      chk({nm, "_pulses"},
          int'({b0.onehot_err, b0.step_err, b0.wrap}), 0);
      chk({nm, "_ec"}, int'(b0.err_count), 0);
   endtask

   initial begin
      logic [W-1:0] seq [5];
      int           e_idx [5];
      bit           e_lk [5];
      bit           e_wr [5];

      b0.en = 0; b0.ring_in = '0;
      b1.en = 0; b1.ring_in = '0;

      // 1: reset held two cycles
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 0;
      #1;
      chk_zero0("rst");

      // 2: clean rotation with wrap
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      e_idx = '{0, 1, 2, 3, 0};
      e_lk  = '{0, 0, 1, 1, 1};
      e_wr  = '{0, 0, 0, 0, 1};
      for (int i = 0; i < 5; i++) begin
         step(0, 1, seq[i]);
         chk("t2_idx", int'(b0.idx), e_idx[i]);
         chk("t2_lk", int'(b0.locked), int'(e_lk[i]));
         chk("t2_wrap", int'(b0.wrap), int'(e_wr[i]));
         chk("t2_v", int'(b0.idx_valid), 1);
      end
      chk("t2_ec", int'(b0.err_count), 0);

      // 3: advance to index 3, then illegal codes
      step(0, 1, 4'b0010);
      step(0, 1, 4'b0100);
      step(0, 1, 4'b1000);
      step(0, 1, 4'b0000);
      chk("t3_oh1", int'(b0.onehot_err), 1);
      chk("t3_v1", int'(b0.idx_valid), 0);
      chk("t3_lk1", int'(b0.locked), 0);
      chk("t3_idx1", int'(b0.idx), 3);
      step(0, 1, 4'b0110);
      chk("t3_oh2", int'(b0.onehot_err), 1);
      chk("t3_idx2", int'(b0.idx), 3);
      chk("t3_ec", int'(b0.err_count), 2);
      step(0, 1, 4'b0001);
      step(0, 1, 4'b0010);
      chk("t3_nolk", int'(b0.locked), 0);
      step(0, 1, 4'b0100);
      chk("t3_relock", int'(b0.locked), 1);

      // 4: step error from index 1
      step(0, 1, 4'b1000);
      step(0, 1, 4'b0001);
      step(0, 1, 4'b0010);
      chk("t4_lk_pre", int'(b0.locked), 1);
      step(0, 1, 4'b1000);
      chk("t4_st", int'(b0.step_err), 1);
      chk("t4_lk", int'(b0.locked), 0);
      chk("t4_idx", int'(b0.idx), 3);
      chk("t4_ec", int'(b0.err_count), 3);
      step(0, 1, 4'b0001);
      chk("t4_wrap", int'(b0.wrap), 1);
      chk("t4_lk2", int'(b0.locked), 0);
      step(0, 1, 4'b0010);
      chk("t4_relock", int'(b0.locked), 1);

      // 5: enable low holds everything
      step(0, 1, 4'b0100);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, W'($urandom_range(0, 15)));
         chk("t5_pulses",
             int'({b0.onehot_err, b0.step_err, b0.wrap}), 0);
         chk("t5_idx", int'(b0.idx), 2);
         chk("t5_lk", int'(b0.locked), 1);
      end
      step(0, 1, 4'b1000);
      chk("t5_st", int'(b0.step_err), 0);
      chk("t5_idx2", int'(b0.idx), 3);
      chk("t5_ec", int'(b0.err_count), 3);

      // 1b: asynchronous reset between edges while locked
      chk("t1b_lk_pre", int'(b0.locked), 1);
      @(negedge clk);
      #2;
      reset = 1;
      #1;
      chk_zero0("arst");
      @(negedge clk);
      reset = 0;
      b0.en = 0;

      // 6: saturating 2-bit error counter
      for (int i = 0; i < 6; i++) begin
         step(1, 1, (i % 2 == 0) ? 4'b0000 : 4'b1111);
         chk("t6_ec", int'(b1.err_count), (i < 3) ? i + 1 : 3);
         chk("t6_oh", int'(b1.onehot_err), 1);
      end
      step(1, 0, 4'b0000);
      chk("t6_oh_off", int'(b1.onehot_err), 0);

      repeat (2) @(posedge clk);
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
